// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Decode-stage issue controller for the 16-bit-instruction processor.
// A per-register scoreboard counts writes that have issued but not yet
// written back. Decode is held on read-after-write hazards and when a
// destination counter is saturated. Branch, syn and halt instructions
// stall fetch/decode until they resolve.
//
// Handshake: the decoder presents an instruction with i_id_valid. The
// instruction is consumed in the same cycle that o_id_issue is high. While
// i_id_valid is high and o_id_issue is low, the decoder must hold the
// instruction stable; o_stall_id signals exactly that.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_id_valid              decode holds a valid instruction
//   i_id_reg1, i_id_reg2    source registers (reg2 ignored if i_id_use_imm)
//   i_id_use_imm            operand b is the immediate
//   i_id_reg_wr_en          instruction writes i_id_wr_reg
//   i_id_wr_reg             destination register
//   i_id_branch/syn/halt    control-flow flags from the decoder
//   i_br_resolve            execute resolved the outstanding branch (pulse)
//   i_br_taken              branch outcome, qualified by i_br_resolve
//   i_wb_en, i_wb_reg       register-file writeback this cycle
//   i_fft_busy              FFT unit still has outstanding work
//   o_id_issue              instruction accepted into execute this cycle
//   o_stall_id              hold the decode register
//   o_stall_if              hold the PC and fetch register
//   o_flush_if              squash the fetched instruction (one cycle)
//   o_halted                controller is halted (registered)
//   o_sb_err                sticky: writeback to a register with count 0
//   o_dbg_state             current FSM state for observation
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int NUMREGISTERS = 8,
    parameter int REGW         = 3,
    parameter int CNTW         = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_id_valid,
    input  logic [REGW-1:0] i_id_reg1,
    input  logic [REGW-1:0] i_id_reg2,
    input  logic            i_id_use_imm,
    input  logic            i_id_reg_wr_en,
    input  logic [REGW-1:0] i_id_wr_reg,
    input  logic            i_id_branch,
    input  logic            i_id_syn,
    input  logic            i_id_halt,
    input  logic            i_br_resolve,
    input  logic            i_br_taken,
    input  logic            i_wb_en,
    input  logic [REGW-1:0] i_wb_reg,
    input  logic            i_fft_busy,
    output logic            o_id_issue,
    output logic            o_stall_id,
    output logic            o_stall_if,
    output logic            o_flush_if,
    output logic            o_halted,
    output logic            o_sb_err,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_BR_WAIT   = 2'd1,
        ST_SYNC_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTW-1:0]       r_cnt [NUMREGISTERS];
    logic                  r_halted;
    logic                  r_sb_err;

    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_all_zero;
    logic                  w_wb_miss;
    logic [NUMREGISTERS-1:0] w_inc;
    logic [NUMREGISTERS-1:0] w_dec;

    // ------------------------------------------------------------------
    // Hazard detection. A saturated destination counter also blocks
    // issue, otherwise the increment would wrap and lose a pending write.
    // ------------------------------------------------------------------
    always_comb begin
        w_hazard = (r_cnt[i_id_reg1] != '0)
                 | (!i_id_use_imm && (r_cnt[i_id_reg2] != '0))
                 | (i_id_reg_wr_en && (r_cnt[i_id_wr_reg] == CNT_MAX));
    end

    assign w_issue   = i_id_valid && (r_state == ST_RUN) && !w_hazard;
    assign w_wb_miss = i_wb_en && (r_cnt[i_wb_reg] == '0);

    always_comb begin
        w_all_zero = 1'b1;
        for (int i = 0; i < NUMREGISTERS; i++) begin
            if (r_cnt[i] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUMREGISTERS; i++) begin
            w_inc[i] = w_issue && i_id_reg_wr_en && (i_id_wr_reg == REGW'(i));
            w_dec[i] = i_wb_en && (i_wb_reg == REGW'(i)) && (r_cnt[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counters. Same-cycle increment and decrement cancel.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUMREGISTERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMREGISTERS; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNTW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNTW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Control-flow FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_sb_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == ST_HALTED);
            if (w_wb_miss) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control-flow FSM: next state and outputs. When several flags are
    // set on one instruction, halt wins over branch, branch over syn.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_flush_if  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_issue) begin
                    if (i_id_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (i_id_branch) begin
                        w_state_nxt = ST_BR_WAIT;
                    end else if (i_id_syn) begin
                        w_state_nxt = ST_SYNC_WAIT;
                    end
                end
            end
            ST_BR_WAIT: begin
                if (i_br_resolve) begin
                    w_state_nxt = ST_RUN;
                    // A reset in the resolve cycle must not squash fetch.
                    o_flush_if  = i_br_taken && i_rst_n;
                end
            end
            ST_SYNC_WAIT: begin
                if (!i_fft_busy && w_all_zero) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign o_id_issue  = w_issue;
    assign o_stall_id  = (i_id_valid && !w_issue) || (r_state != ST_RUN);
    assign o_stall_if  = o_stall_id || (r_state != ST_RUN);
    assign o_halted    = r_halted;
    assign o_sb_err    = r_sb_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int NREG = 8;
  localparam int PEND_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 0;
  logic [2:0] id_reg1 = 0, id_reg2 = 0, id_wr_reg = 0, wb_reg = 0;
  logic       id_use_imm = 0, id_reg_wr_en = 0;
  logic       id_branch = 0, id_syn = 0, id_halt = 0;
  logic       br_resolve = 0, br_taken = 0, wb_en = 0, fft_busy = 0;

  logic       id_issue, stall_id, stall_if, flush_if, halted, sb_err;
  logic [1:0] dbg_state;

  hazard_ctrl #(.NUMREGISTERS(8), .REGW(3), .CNTW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_reg1(id_reg1), .i_id_reg2(id_reg2), .i_id_use_imm(id_use_imm),
    .i_id_reg_wr_en(id_reg_wr_en), .i_id_wr_reg(id_wr_reg),
    .i_id_branch(id_branch), .i_id_syn(id_syn), .i_id_halt(id_halt),
    .i_br_resolve(br_resolve), .i_br_taken(br_taken),
    .i_wb_en(wb_en), .i_wb_reg(wb_reg), .i_fft_busy(fft_busy),
    .o_id_issue(id_issue), .o_stall_id(stall_id), .o_stall_if(stall_if),
    .o_flush_if(flush_if), .o_halted(halted), .o_sb_err(sb_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Pending-write counts per register and the kind of event the
  // controller is currently waiting on.
  localparam int WAIT_NONE = 0, WAIT_BRANCH = 1, WAIT_DRAIN = 2, WAIT_FOREVER = 3;
  int pend [NREG];
  int waiting;
  bit m_err;

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) pend[i] = 0;
    waiting = WAIT_NONE;
    m_err = 0;
  endtask

  // One clock cycle: inputs are already applied. Predict this cycle's
  // outputs, queue them, then advance the model across the edge.
  task automatic step();
    bit blocked, take, hold, fl, drained;
    int old_wb;
    blocked = (pend[id_reg1] > 0) || (!id_use_imm && pend[id_reg2] > 0) ||
              (id_reg_wr_en && pend[id_wr_reg] == PEND_MAX);
    take = id_valid && waiting == WAIT_NONE && !blocked;
    hold = (id_valid && !take) || waiting != WAIT_NONE;
    fl   = rst_n && waiting == WAIT_BRANCH && br_resolve && br_taken;
    exp_q.push_back({take, hold, hold, fl, (waiting == WAIT_FOREVER), m_err});
    drained = !fft_busy;
    for (int i = 0; i < NREG; i++) if (pend[i] != 0) drained = 0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      old_wb = pend[wb_reg];
      if (take && id_reg_wr_en) pend[id_wr_reg] = pend[id_wr_reg] + 1;
      if (wb_en) begin
        if (old_wb > 0) pend[wb_reg] = pend[wb_reg] - 1;
        else m_err = 1;
      end
      if (waiting == WAIT_NONE && take) begin
        if (id_halt) waiting = WAIT_FOREVER;
        else if (id_branch) waiting = WAIT_BRANCH;
        else if (id_syn) waiting = WAIT_DRAIN;
      end else if (waiting == WAIT_BRANCH && br_resolve) begin
        waiting = WAIT_NONE;
      end else if (waiting == WAIT_DRAIN && drained) begin
        waiting = WAIT_NONE;
      end
    end
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [5:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {id_issue, stall_id, stall_if, flush_if, halted, sb_err};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL outputs t=%0t {issue,stall_id,stall_if,flush_if,halted,sb_err} got=%b want=%b",
                 $time, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_reg1 = 0; id_reg2 = 0; id_use_imm = 1; id_reg_wr_en = 0;
    id_wr_reg = 0; id_branch = 0; id_syn = 0; id_halt = 0;
    br_resolve = 0; br_taken = 0; wb_en = 0; wb_reg = 0;
  endtask

  task automatic instr(input int r1, input int r2, input bit imm, input bit wen,
                       input int wr, input bit br, input bit syn, input bit hlt);
    id_valid = 1; id_reg1 = 3'(r1); id_reg2 = 3'(r2); id_use_imm = imm;
    id_reg_wr_en = wen; id_wr_reg = 3'(wr);
    id_branch = br; id_syn = syn; id_halt = hlt;
  endtask

  task automatic wb(input bit en, input int r);
    wb_en = en; wb_reg = 3'(r);
  endtask

  task automatic pulse_reset();
    rst_n = 0; step(); rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step();                          // reset state, idle decode

    // RAW: r3 <- (r1,r2), then r4 <- (r3,imm) held until writeback of r3
    instr(1, 2, 0, 1, 3, 0, 0, 0); step();
    instr(3, 0, 1, 1, 4, 0, 0, 0); repeat (3) step();
    wb(1, 3); step();
    wb(0, 0); step();                // issues here
    instr(3, 3, 0, 0, 0, 0, 0, 0); step();  // r3 clear again
    idle(); wb(1, 4); step(); wb(0, 0);

    // WAW saturation on r5
    repeat (3) begin instr(0, 0, 1, 1, 5, 0, 0, 0); step(); end
    step();                          // 4th write blocked
    wb(1, 5); step();
    wb(0, 0); step();                // 4th issues
    idle(); step();
    repeat (3) begin wb(1, 5); step(); end
    wb(0, 0);

    // Same-cycle issue and writeback on r2, then orphan writeback to r6
    instr(0, 0, 1, 1, 2, 0, 0, 0); step();
    instr(0, 0, 1, 1, 2, 0, 0, 0); wb(1, 2); step();
    idle(); step();
    wb(1, 6); step();
    wb(1, 2); step();
    idle(); repeat (2) step();

    // Branch taken then not taken, resolve 4 cycles after issue
    for (int tk = 1; tk >= 0; tk--) begin
      instr(0, 0, 1, 0, 0, 1, 0, 0); step();
      instr(0, 0, 1, 0, 0, 0, 0, 0); repeat (3) step();
      br_resolve = 1; br_taken = tk[0]; step();
      br_resolve = 0; br_taken = 0; step();
      idle(); step();
    end
    br_resolve = 1; br_taken = 1; step();  // stray resolve in RUN
    idle();

    // Syn with fft busy and r1 pending
    instr(0, 0, 1, 1, 1, 0, 0, 0); step();
    instr(0, 0, 1, 0, 0, 0, 1, 0); fft_busy = 1; step();
    instr(2, 2, 0, 0, 0, 0, 0, 0); repeat (2) step();
    fft_busy = 0; step();
    wb(1, 1); step();
    wb(0, 0); step();
    step();
    idle(); step();

    // Halt, then reset; then reset while waiting on a branch
    instr(0, 0, 1, 1, 7, 0, 0, 1); step();
    instr(0, 0, 1, 0, 0, 0, 0, 0); repeat (3) step();
    wb(1, 7); step(); wb(0, 0); step();
    idle(); pulse_reset(); step();
    instr(0, 0, 1, 0, 0, 1, 0, 0); step();
    idle(); step();
    br_resolve = 1; br_taken = 1; pulse_reset();
    idle(); repeat (2) step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_valid     = ($urandom_range(0, 99) < 70);
      id_reg1      = 3'($urandom_range(0, 7));
      id_reg2      = 3'($urandom_range(0, 7));
      id_use_imm   = $urandom_range(0, 1);
      id_reg_wr_en = ($urandom_range(0, 99) < 60);
      id_wr_reg    = 3'($urandom_range(0, 7));
      id_branch    = ($urandom_range(0, 99) < 6);
      id_syn       = ($urandom_range(0, 99) < 5);
      id_halt      = ($urandom_range(0, 999) < 8);
      br_resolve   = ($urandom_range(0, 99) < 25);
      br_taken     = $urandom_range(0, 1);
      wb_en        = ($urandom_range(0, 99) < 45);
      wb_reg       = 3'($urandom_range(0, 7));
      fft_busy     = ($urandom_range(0, 99) < 30);
      rst_n        = !($urandom_range(0, 999) < 6);
      step();
    end
    rst_n = 1; idle(); fft_busy = 0; step();

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
